cla_seq_adder: RTL and testbench

Multi-cycle WIDTH-bit adder/subtractor that reuses a single 4-bit carry-lookahead slice. The slice computes P = A^B and G = A&B and produces full lookahead carries. The block processes one nibble per clock, least significant nibble first, and keeps the inter-nibble carry in a register. It sits beside the 4-bit CLA datapath as its sequencing controller: it latches operands, steps the slice through each nibble, and reports the result with a start/busy/done handshake.

---
 rtl/cla_seq_adder.sv | 104 ++++++++++
 tb/tb_cla_seq_adder.sv | 110 +++++++++++
 2 files changed

// File: rtl/cla_seq_adder.sv
// cla_seq_adder: multi-cycle adder/subtractor stepping one 4-bit CLA slice per nibble
module cla_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int N  = WIDTH / 4;
  localparam int IW = $clog2(N);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, sum_q, sum_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;
  logic [3:0]       na, nb, p, g, s;
  logic [4:0]       c;
  logic             last;
  // 4-bit carry-lookahead slice on the current nibble of the latched operands
  always_comb begin
    na   = opa_q[{idx_q, 2'b00} +: 4];
    nb   = opb_q[{idx_q, 2'b00} +: 4];
    p    = na ^ nb;
    g    = na & nb;
    c[0] = carry_q;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    s    = p ^ c[3:0];
  end
  // sequencing: accept operands, one slice step per RUN cycle, single DONE cycle
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    last    = idx_q == IW'(N - 1);
    if (state_q == IDLE) begin
      if (start) begin
        state_d = RUN;
        opa_d   = a;
        opb_d   = sub ? ~b : b;
        carry_d = sub;
        idx_d   = '0;
        sum_d   = '0;
        cout_d  = 1'b0;
        ovf_d   = 1'b0;
      end
    end else if (state_q == RUN) begin
      sum_d[{idx_q, 2'b00} +: 4] = s;
      carry_d = c[4];
      idx_d   = idx_q + 1'b1;
      if (last) begin
        state_d = DONE;
        cout_d  = c[4];
        ovf_d   = c[3] ^ c[4];
      end
    end else begin
      state_d = IDLE;
    end
  end
  // state register with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_cla_seq_adder.sv
// tb_cla_seq_adder: table, random and handshake/reset checks for cla_seq_adder
module tb_cla_seq_adder;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, sub = 1'b0;
  logic [15:0] a = '0, b = '0, sum;
  logic        busy, done, cout, ovf;
  int          total = 0, bad = 0;
  typedef struct {
    logic [15:0] a, b;
    logic        sub;
    logic [15:0] s;
    logic        co, ov;
  } vec_t;
  vec_t tbl[5];
  cla_seq_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask
  // reference: plain integer arithmetic on the operands
  task automatic model(input logic [15:0] x, input logic [15:0] y, input logic s,
                       output logic [15:0] rs, output logic co, output logic ov);
    int sr;
    sr = s ? $signed(x) - $signed(y) : $signed(x) + $signed(y);
    rs = s ? x - y : x + y;
    co = s ? (x >= y) : ((int'(x) + int'(y)) > 65535);
    ov = (sr > 32767) || (sr < -32768);
  endtask
  // caller sits at a negedge in IDLE; returns at a negedge back in IDLE
  task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic s,
                       input logic [15:0] es, input logic eco, input logic eov);
    a = x; b = y; sub = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; sub = $urandom;
    for (int i = 0; i < 4; i++) begin
      chk("busy_run", {busy, done}, 2'b10);
      @(negedge clk);
    end
    chk("done_pulse", {busy, done}, 2'b01);
    chk("sum", sum, es);
    chk("cout", cout, eco);
    chk("ovf", ovf, eov);
    @(negedge clk);
    chk("idle_after", {busy, done}, 2'b00);
    chk("sum_held", sum, es);
  endtask
  initial begin
    logic [15:0] rs;
    logic        co, ov;
    tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    #2;
    chk("reset_outs", {busy, done, sum, cout, ovf}, 32'h0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++)
      do_op(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].s, tbl[i].co, tbl[i].ov);
    for (int i = 0; i < 40; i++) begin
      logic [15:0] x, y;
      logic        s;
      x = $urandom; y = $urandom; s = $urandom;
      if (i == 0) begin x = 16'h0; y = 16'h0; s = 1'b1; end
      model(x, y, s, rs, co, ov);
      do_op(x, y, s, rs, co, ov);
    end
    // starts during RUN and DONE are dropped; the next IDLE start is taken
    a = 16'h1234; b = 16'h4321; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("hs_still_busy", {busy, done}, 2'b10);
    @(negedge clk);
    chk("hs_done", {busy, done}, 2'b01);
    chk("hs_sum", sum, 16'h5555);
    chk("hs_cout_ovf", {cout, ovf}, 2'b00);
    a = 16'h7FFF; b = 16'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("hs_done_start_lost", {busy, done}, 2'b00);
    chk("hs_sum_kept", sum, 16'h5555);
    do_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    // asynchronous reset in the second RUN cycle
    a = 16'h1234; b = 16'h4321; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_rst_partial", sum, 16'h0005);
    #2 rst = 1'b1;
    #1 chk("async_rst", {busy, done, sum, cout, ovf}, 32'h0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", {busy, done}, 2'b00);
    do_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
